// File: rtl/blink_pkg.sv
// Shared types and constants for the LED blink scheduler.
// Holds the FSM state encoding, per-requester count width and default size.
package blink_pkg;

    localparam int CNT_W    = 4;
    localparam int DEF_NREQ = 4;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF,
        GAP
    } state_t;

endpackage

// File: rtl/blink_prescaler.sv
// Free-running tick prescaler with synchronous clear.
// tick is registered and high during the last cycle of each TICK_DIV period.
module blink_prescaler #(
    parameter int TICK_DIV = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    // Count 0..TICK_DIV-1; tick is raised one cycle early so it lines up with the wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == CW'(TICK_DIV - 2));
            cnt  <= (cnt == CW'(TICK_DIV - 1)) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/blink_sched.sv
// Round-robin LED blink scheduler: grants the LED to one requester and
// blinks it cnt times (ON/OFF phases) followed by a dark GAP, then signals done.
module blink_sched
    import blink_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int TICK_DIV  = 1000000,
    parameter int ON_TICKS  = 2,
    parameter int OFF_TICKS = 2,
    parameter int GAP_TICKS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CNT_W-1:0] cnt_in,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  led,
    output logic                  busy,
    output logic                  tick
);

    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int MX1  = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int MAXT = (MX1 > GAP_TICKS) ? MX1 : GAP_TICKS;
    localparam int TW   = (MAXT > 1) ? $clog2(MAXT) : 1;

    state_t           state;
    state_t           state_n;
    logic [NREQ-1:0]  grant_n;
    logic [NREQ-1:0]  done_n;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] rem_n;
    logic [TW-1:0]    tcnt;
    logic [TW-1:0]    tcnt_n;
    logic [IW-1:0]    own;
    logic [IW-1:0]    own_n;
    logic [IW-1:0]    last;
    logic [IW-1:0]    last_n;
    logic [IW-1:0]    pick;
    logic             found;
    logic             clr;
    logic [CNT_W-1:0] cnt_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_cnt
        assign cnt_arr[g] = cnt_in[g*CNT_W +: CNT_W];
    end

    blink_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_pre (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .tick(tick)
    );

    // Round-robin search starting just after the last served requester.
    always_comb begin
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[IW'((int'(last) + k) % NREQ)]) begin
                found = 1'b1;
                pick  = IW'((int'(last) + k) % NREQ);
            end
        end
    end

    // Next-state logic: phases advance only on the last tick of each phase.
    always_comb begin
        state_n = state;
        grant_n = grant;
        done_n  = '0;
        rem_n   = rem;
        tcnt_n  = tcnt;
        own_n   = own;
        last_n  = last;
        clr     = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    clr     = 1'b1;
                    own_n   = pick;
                    grant_n = NREQ'(1) << pick;
                    rem_n   = cnt_arr[pick];
                    tcnt_n  = '0;
                    state_n = (cnt_arr[pick] != '0) ? ON : GAP;
                end
            end
            ON: begin
                if (tick) begin
                    if (tcnt == TW'(ON_TICKS - 1)) begin
                        state_n = OFF;
                        tcnt_n  = '0;
                        rem_n   = rem - 1'b1;
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
            end
            OFF: begin
                if (tick) begin
                    if (tcnt == TW'(OFF_TICKS - 1)) begin
                        state_n = (rem != '0) ? ON : GAP;
                        tcnt_n  = '0;
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (tcnt == TW'(GAP_TICKS - 1)) begin
                        state_n = IDLE;
                        tcnt_n  = '0;
                        done_n  = grant;
                        grant_n = '0;
                        last_n  = own;
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any service silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            done  <= '0;
            led   <= 1'b0;
            busy  <= 1'b0;
            rem   <= '0;
            tcnt  <= '0;
            own   <= '0;
            last  <= IW'(NREQ - 1);
        end else begin
            state <= state_n;
            grant <= grant_n;
            done  <= done_n;
            led   <= (state_n == ON);
            busy  <= |grant_n;
            rem   <= rem_n;
            tcnt  <= tcnt_n;
            own   <= own_n;
            last  <= last_n;
        end
    end

endmodule

// File: tb/tb_blink_sched.sv
// Self-checking bench for blink_sched: directed vector table, hand-written
// arbitration/reset sequences and randomized traffic against a timeline model.
module tb_blink_sched;

    localparam int NREQ  = 4;
    localparam int TD    = 4;
    localparam int ONT   = 2;
    localparam int OFFT  = 2;
    localparam int GAPT  = 4;
    localparam int ON_C  = ONT * TD;
    localparam int OFF_C = OFFT * TD;
    localparam int GAP_C = GAPT * TD;
    localparam int BL_C  = ON_C + OFF_C;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] cnt_in = '0;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        led;
    logic        busy;
    logic        tick;

    blink_sched #(
        .NREQ     (NREQ),
        .TICK_DIV (TD),
        .ON_TICKS (ONT),
        .OFF_TICKS(OFFT),
        .GAP_TICKS(GAPT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .cnt_in(cnt_in),
        .grant (grant),
        .done  (done),
        .led   (led),
        .busy  (busy),
        .tick  (tick)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Timeline model: a service is a grant time plus a latched count; every
    // output is a plain arithmetic function of the cycles elapsed since grant.
    bit         m_busy;
    int         m_own;
    int         m_cnt;
    int         m_age;
    int         m_last;
    int         m_pc;
    int         m_done;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] cnt;
        logic [3:0]  exp_grant;
        int          blinks;
        int          done_dly;
        int          drop;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_own  = 0;
        m_cnt  = 0;
        m_age  = 0;
        m_last = NREQ - 1;
        m_pc   = 0;
        m_done = 0;
    endtask

    task automatic model_edge();
        bit hit;
        m_done = 0;
        if (!m_busy) begin
            if (req != 0) begin
                hit = 1'b0;
                for (int k = 1; k <= NREQ; k++) begin
                    if (!hit && req[(m_last + k) % NREQ]) begin
                        hit   = 1'b1;
                        m_own = (m_last + k) % NREQ;
                    end
                end
                m_busy = 1'b1;
                m_cnt  = (int'(cnt_in) >> (4 * m_own)) & 15;
                m_age  = 0;
                m_pc   = 0;
            end else begin
                m_pc++;
            end
        end else begin
            m_age++;
            m_pc++;
            if (m_age == m_cnt * BL_C + GAP_C) begin
                m_busy = 1'b0;
                m_done = 1 << m_own;
                m_last = m_own;
            end
        end
    endtask

    task automatic check_outputs();
        int eg;
        int el;
        eg = m_busy ? (1 << m_own) : 0;
        el = (m_busy && m_age < m_cnt * BL_C && (m_age % BL_C) < ON_C) ? 1 : 0;
        chk("grant", int'(grant), eg);
        chk("done", int'(done), m_done);
        chk("led", int'(led), el);
        chk("busy", int'(busy), m_busy ? 1 : 0);
        chk("tick", int'(tick), ((m_pc % TD) == TD - 1) ? 1 : 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && busy; i++) cycle();
        chk("drain_timeout", int'(busy), 0);
        cycle();
    endtask

    function automatic int owner_of(input logic [3:0] g);
        int o;
        o = -1;
        for (int i = 0; i < 4; i++) if (g[i]) o = i;
        return o;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int g_at;
        int d_at;
        int highs;
        int rises;
        int nobusy;
        logic prev;
        req    = v.req;
        cnt_in = v.cnt;
        g_at   = -1;
        for (int i = 0; i < 20 && g_at < 0; i++) begin
            cycle();
            if (grant != 0) g_at = cyc;
        end
        chk($sformatf("v%0d_grant", idx), int'(grant), int'(v.exp_grant));
        highs  = int'(led);
        rises  = int'(led);
        prev   = led;
        nobusy = busy ? 0 : 1;
        d_at   = -1;
        for (int i = 0; i < 400 && d_at < 0; i++) begin
            if (cyc - g_at == v.drop) begin
                req    = '0;
                cnt_in = 16'($urandom);
            end
            cycle();
            if (done != 0) begin
                d_at = cyc;
                chk($sformatf("v%0d_done_owner", idx), int'(done), int'(v.exp_grant));
            end else begin
                highs += int'(led);
                if (led && !prev) rises++;
                prev = led;
                if (!busy) nobusy++;
            end
        end
        chk($sformatf("v%0d_done_delay", idx), d_at - g_at, v.done_dly);
        chk($sformatf("v%0d_blinks", idx), rises, v.blinks);
        chk($sformatf("v%0d_led_cycles", idx), highs, v.blinks * ON_C);
        chk($sformatf("v%0d_busy_gaps", idx), nobusy, 0);
        req    = '0;
        cnt_in = '0;
        cycle();
    endtask

    task automatic rr_seq(input logic [3:0] r, input logic [15:0] c, input int n,
                          input logic [31:0] order, input string nm);
        int ng;
        int last_done;
        int prev;
        do_reset();
        req       = r;
        cnt_in    = c;
        ng        = 0;
        last_done = -100;
        prev      = 0;
        for (int i = 0; i < 600 && ng < n; i++) begin
            cycle();
            if (done != 0) last_done = cyc;
            if (grant != 0 && prev == 0) begin
                chk({nm, "_owner"}, owner_of(grant), int'(order[4*ng +: 4]));
                if (ng > 0) chk({nm, "_idle_gap"}, cyc - last_done, 1);
                ng++;
            end
            prev = int'(grant);
        end
        chk({nm, "_grants"}, ng, n);
        req = '0;
        drain();
    endtask

    task automatic mid_on_reset();
        int g_at;
        do_reset();
        req    = 4'b0001;
        cnt_in = 16'h0002;
        g_at   = -1;
        for (int i = 0; i < 20 && g_at < 0; i++) begin
            cycle();
            if (grant != 0) g_at = cyc;
        end
        chk("mr_grant", int'(grant), 1);
        for (int i = 0; i < 3; i++) cycle();
        chk("mr_led_before", int'(led), 1);
        rst = 1'b1;
        model_reset();
        req = 4'b0101;
        #1;
        chk("mr_led_now", int'(led), 0);
        chk("mr_grant_now", int'(grant), 0);
        chk("mr_busy_now", int'(busy), 0);
        @(posedge clk);
        #1;
        chk("mr_no_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        cycle();
        chk("mr_first_grant", int'(grant), 1);
        req = '0;
        drain();
    endtask

    initial begin
        model_reset();
        #1;
        check_outputs();
        chk("reset_grant", int'(grant), 0);
        chk("reset_led", int'(led), 0);
        @(negedge clk);
        rst = 1'b0;
        cycle();

        vt[0] = '{4'b0001, 16'h0003, 4'b0001, 3, 64, -1};
        vt[1] = '{4'b0010, 16'h0000, 4'b0010, 0, 16, -1};
        vt[2] = '{4'b0001, 16'h0002, 4'b0001, 2, 48, 2};
        vt[3] = '{4'b1000, 16'hF000, 4'b1000, 15, 256, -1};
        vt[4] = '{4'b0100, 16'h0100, 4'b0100, 1, 32, 3};
        for (int i = 0; i < 5; i++) run_vec(vt[i], i);

        rr_seq(4'b1111, 16'h1111, 5, 32'h0000_3210, "rr_all");
        rr_seq(4'b0101, 16'h0101, 4, 32'h0000_2020, "rr_02");
        mid_on_reset();

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) req = 4'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                for (int k = 0; k < 4; k++) cnt_in[4*k +: 4] = 4'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                model_reset();
                #1;
                check_outputs();
                @(negedge clk);
                rst = 1'b0;
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
